writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Write-back stage feeding the single write port (port 0) of the integer register file.
//  Collects results from N_SRC producers (e.g. 0=ALU, 1=LSU, 2=MULDIV) through per-source 2-entry FIFOs.
//  Round-robin arbitrates among the FIFOs and emits at most one register write per cycle.
//  Reports pending-write hazards for the two decode read addresses.
// PARAMETERS
//  N_SRC   3   number of result producers (>=2)
//  N_REGS  32  register count; W_ADDR=$clog2(N_REGS) (localparam)
//  R_WIDTH 32  register data width
//  DEPTH   2   per-source FIFO depth (power of 2, >=2)
// PORTS
//  clk        in   1              clock, all state on posedge
//  rst        in   1              synchronous reset, active-high
//  src_valid  in   N_SRC          producer i has a result
//  src_ready  out  N_SRC          FIFO i can accept; transfer when valid&&ready
//  src_addr   in   N_SRC*W_ADDR   dest reg of src i, slice [i*W_ADDR +: W_ADDR]
//  src_data   in   N_SRC*R_WIDTH  result of src i, slice [i*R_WIDTH +: R_WIDTH]
//  rf_write   out  1              write strobe to register file port 0
//  rf_addr    out  W_ADDR         write address to register file
//  rf_data    out  R_WIDTH        write data to register file
//  rd1_addr   in   W_ADDR         decode read address 1 (hazard query)
//  rd2_addr   in   W_ADDR         decode read address 2 (hazard query)
//  hazard1    out  1              write pending to rd1_addr
//  hazard2    out  1              write pending to rd2_addr
// BEHAVIOUR
//  - Reset (rst sampled high): all FIFOs emptied, rr_ptr=0. Next cycle: rf_write=0, rf_addr=0, rf_data=0.
//    src_ready=0 while rst=1. Entries in flight at reset are discarded and never written.
//  - src_ready[i] = !rst && count[i]<DEPTH. It does not depend on a same-cycle pop, so there is no comb path from arbitration.
//  - Accept with src_addr==0: handshake completes, nothing enqueued (x0 writes dropped).
//  - Push with count==DEPTH cannot occur. If one happens, it is ignored and an SVA assertion fires.
//  - Cycle T: accept. Cycle T+1: entry is arbitration-eligible.
//    Cycle T+2: rf_write=1 with that addr/data, one cycle only; the register file captures at end of T+2.
//    Latency is 2 cycles with no contention.
//  - Arbitration each cycle: grant the first non-empty FIFO searching from rr_ptr upward, modulo N_SRC.
//    On a grant, rr_ptr <= granted+1 (wrapping to 0 after N_SRC-1). With no grant, rr_ptr holds.
//  - Output stage is a register loaded every cycle: rf_write<=|nonempty, rf_addr/rf_data<=granted head.
//    On an idle cycle rf_addr/rf_data hold their last value and rf_write=0.
//    The sink always accepts, so throughput is 1 write/cycle.
//  - A simultaneous push and pop on the same FIFO is legal when count<DEPTH; count is unchanged.
//    A push into an empty FIFO is not visible to the arbiter in the same cycle.
//  - Ordering: FIFO order within a source. Cross-source same-address order is not guaranteed.
//    The issue stage must use hazard1/2 and in-flight tracking to avoid cross-source WAW.
//  - hazardN (combinational) = rdN_addr!=0 AND the address matches any valid FIFO entry
//    or the output stage while rf_write=1.
//    Same-cycle incoming src_valid is not included.
//  - Pointer/count arithmetic wraps modulo DEPTH. Counts are $clog2(DEPTH)+1 bits wide.
// TESTING
//  1. Reset: hold rst 2 cycles with src_valid=3'b111 -> src_ready=0, rf_write=0, no writes after release.
//  2. Single: src0 addr=5, data=32'hDEAD_BEEF at T -> rf_write=1, rf_addr=5 at T+2 only; hazard1=1 for rd1_addr=5 during T+1..T+2.
//  3. Contention: all 3 sources valid every cycle, from reset -> grant order 0,1,2,0,1,2.
//     src_ready drops to 0 when count==2; no data lost or duplicated.
//  4. x0 drop: src1 addr=0, data=32'h1234 accepted -> rf_write never asserts; hazard1=0 for rd1_addr=0.
//  5. Backpressure order: src2 pushes addrs 7,8 back-to-back while src0 is busy -> rf_addr sequence for src2 is 7 then 8.
//  6. Mid-op reset: FIFOs full, assert rst 1 cycle -> following cycles rf_write=0, hazards=0, src_ready=3'b111 after release.

Source files
------------

// File: rtl/writeback_if.sv
// Write-back bundle: producer result channels, register-file write port and decode hazard queries.
interface writeback_if #(
  parameter int unsigned N_SRC   = 3,
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned R_WIDTH = 32
);
  localparam int unsigned W_ADDR = $clog2(N_REGS);

  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC-1:0]         src_ready;
  logic [N_SRC*W_ADDR-1:0]  src_addr;
  logic [N_SRC*R_WIDTH-1:0] src_data;
  logic                     rf_write;
  logic [W_ADDR-1:0]        rf_addr;
  logic [R_WIDTH-1:0]       rf_data;
  logic [W_ADDR-1:0]        rd1_addr;
  logic [W_ADDR-1:0]        rd2_addr;
  logic                     hazard1;
  logic                     hazard2;

  // Producers, register file and decode all sit on the master side.
  modport master (
    output src_valid, src_addr, src_data, rd1_addr, rd2_addr,
    input  src_ready, rf_write, rf_addr, rf_data, hazard1, hazard2
  );

  modport slave (
    input  src_valid, src_addr, src_data, rd1_addr, rd2_addr,
    output src_ready, rf_write, rf_addr, rf_data, hazard1, hazard2
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back stage: per-source result FIFOs, round-robin arbitration onto register-file
// write port 0, and pending-write hazard detection for the two decode read addresses.
module writeback_arbiter #(
  parameter int unsigned N_SRC   = 3,
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned R_WIDTH = 32,
  parameter int unsigned DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  writeback_if.slave  bus
);

  localparam int unsigned W_ADDR = $clog2(N_REGS);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SRC_W  = $clog2(N_SRC);

  logic [W_ADDR-1:0]  addr_q [N_SRC][DEPTH];
  logic [R_WIDTH-1:0] data_q [N_SRC][DEPTH];
  logic [PTR_W-1:0]   wr_ptr [N_SRC];
  logic [PTR_W-1:0]   rd_ptr [N_SRC];
  logic [CNT_W-1:0]   count  [N_SRC];

  logic [N_SRC-1:0]   ready;
  logic [N_SRC-1:0]   nonempty;
  logic [N_SRC-1:0]   push_req;
  logic [N_SRC-1:0]   push;
  logic [N_SRC-1:0]   pop;

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant;
  logic               grant_vld;
  logic [SRC_W:0]     search_idx;
  logic [W_ADDR-1:0]  head_addr;
  logic [R_WIDTH-1:0] head_data;

  logic               rf_write_q;
  logic [W_ADDR-1:0]  rf_addr_q;
  logic [R_WIDTH-1:0] rf_data_q;

  logic [PTR_W-1:0]   slot_off;
  logic               hazard1_c;
  logic               hazard2_c;

  // Ready depends only on occupancy, never on this cycle's pop; x0 results complete the handshake but are dropped.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push_req = '0;
    push     = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      nonempty[i] = (count[i] != '0);
      ready[i]    = !rst && (count[i] < CNT_W'(DEPTH));
      push_req[i] = bus.src_valid[i] && ready[i] &&
                    (bus.src_addr[i*W_ADDR +: W_ADDR] != '0);
      push[i]     = push_req[i] && (count[i] < CNT_W'(DEPTH));
    end
  end

  // Round-robin: first non-empty FIFO at or after rr_ptr, modulo N_SRC.
  always_comb begin
    grant      = '0;
    grant_vld  = 1'b0;
    search_idx = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      search_idx = (SRC_W+1)'(rr_ptr) + (SRC_W+1)'(k);
      if (search_idx >= (SRC_W+1)'(N_SRC)) begin
        search_idx = search_idx - (SRC_W+1)'(N_SRC);
      end
      if (!grant_vld && nonempty[SRC_W'(search_idx)]) begin
        grant     = SRC_W'(search_idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      pop[i] = grant_vld && (grant == SRC_W'(i));
    end
    head_addr = addr_q[grant][rd_ptr[grant]];
    head_data = data_q[grant][rd_ptr[grant]];
  end

  // FIFO storage carries no reset; validity comes from the pointers and counts.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (!rst && push[i]) begin
        addr_q[i][wr_ptr[i]] <= bus.src_addr[i*W_ADDR +: W_ADDR];
        data_q[i][wr_ptr[i]] <= bus.src_data[i*R_WIDTH +: R_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Output stage loads every cycle; address and data hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      rf_write_q <= grant_vld;
      if (grant_vld) begin
        rf_addr_q <= head_addr;
        rf_data_q <= head_data;
        rr_ptr    <= (grant == SRC_W'(N_SRC - 1)) ? '0 : grant + SRC_W'(1);
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    hazard1_c = 1'b0;
    hazard2_c = 1'b0;
    slot_off  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        slot_off = PTR_W'(j) - rd_ptr[i];
        if (CNT_W'(slot_off) < count[i]) begin
          if (addr_q[i][j] == bus.rd1_addr) hazard1_c = 1'b1;
          if (addr_q[i][j] == bus.rd2_addr) hazard2_c = 1'b1;
        end
      end
    end
    if (rf_write_q && (rf_addr_q == bus.rd1_addr)) hazard1_c = 1'b1;
    if (rf_write_q && (rf_addr_q == bus.rd2_addr)) hazard2_c = 1'b1;
    if (bus.rd1_addr == '0) hazard1_c = 1'b0;
    if (bus.rd2_addr == '0) hazard2_c = 1'b0;
  end

  assign bus.src_ready = ready;
  assign bus.rf_write  = rf_write_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_data   = rf_data_q;
  assign bus.hazard1   = hazard1_c;
  assign bus.hazard2   = hazard2_c;

  // An accepted result arriving at a full FIFO would be lost; it is ignored and flagged.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ovf_chk
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push_req[gi] && (count[gi] == CNT_W'(DEPTH))))
      else $error("writeback_arbiter: push into full FIFO %0d", gi);
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: table-driven contention vectors plus hand sequences
// for reset, single-write latency, x0 drop, per-source ordering and mid-operation reset.
module tb_writeback_arbiter;

  localparam int unsigned N_SRC   = 3;
  localparam int unsigned N_REGS  = 32;
  localparam int unsigned R_WIDTH = 32;
  localparam int unsigned W_ADDR  = 5;

  typedef struct {
    logic [W_ADDR-1:0]  rd1;
    logic [N_SRC-1:0]   ready;
    logic               wr;
    logic [W_ADDR-1:0]  addr;
    logic [R_WIDTH-1:0] data;
    logic               hz1;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  writeback_if #(.N_SRC(N_SRC), .N_REGS(N_REGS), .R_WIDTH(R_WIDTH)) bus ();

  writeback_arbiter #(
    .N_SRC(N_SRC), .N_REGS(N_REGS), .R_WIDTH(R_WIDTH), .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [W_ADDR-1:0] a,
                         input logic [R_WIDTH-1:0] d);
    bus.src_valid[s]               = v;
    bus.src_addr[s*W_ADDR +: W_ADDR]   = a;
    bus.src_data[s*R_WIDTH +: R_WIDTH] = d;
  endtask

  vec_t             vecs [13];
  int               item [N_SRC];
  logic [N_SRC-1:0] acc;
  logic [W_ADDR-1:0] seq0 [4];
  logic [W_ADDR-1:0] seq2 [4];
  int               n0, n2, ntot;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Contention from reset: rr order 0,1,2 with src s writing addr s+1, data A00s_00kk.
    vecs[0]  = '{5'd1, 3'b111, 1'b0, 5'd0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{5'd2, 3'b111, 1'b0, 5'd0, 32'h0000_0000, 1'b1};
    vecs[2]  = '{5'd3, 3'b001, 1'b1, 5'd1, 32'hA000_0000, 1'b1};
    vecs[3]  = '{5'd0, 3'b010, 1'b1, 5'd2, 32'hA001_0000, 1'b0};
    vecs[4]  = '{5'd5, 3'b100, 1'b1, 5'd3, 32'hA002_0000, 1'b0};
    vecs[5]  = '{5'd1, 3'b001, 1'b1, 5'd1, 32'hA000_0001, 1'b1};
    vecs[6]  = '{5'd7, 3'b010, 1'b1, 5'd2, 32'hA001_0001, 1'b0};
    vecs[7]  = '{5'd7, 3'b100, 1'b1, 5'd3, 32'hA002_0001, 1'b0};
    vecs[8]  = '{5'd7, 3'b001, 1'b1, 5'd1, 32'hA000_0002, 1'b0};
    vecs[9]  = '{5'd7, 3'b010, 1'b1, 5'd2, 32'hA001_0002, 1'b0};
    vecs[10] = '{5'd7, 3'b100, 1'b1, 5'd3, 32'hA002_0002, 1'b0};
    vecs[11] = '{5'd7, 3'b001, 1'b1, 5'd1, 32'hA000_0003, 1'b0};
    vecs[12] = '{5'd7, 3'b010, 1'b1, 5'd2, 32'hA001_0003, 1'b0};

    // Reset held two cycles with all producers valid.
    rst          = 1'b1;
    bus.rd1_addr = '0;
    bus.rd2_addr = '0;
    for (int s = 0; s < N_SRC; s++) set_src(s, 1'b1, W_ADDR'(s + 9), 32'h5555_0000 + 32'(s));
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      check("reset_ready", 64'(bus.src_ready), 64'(3'b000));
      check("reset_write", 64'(bus.rf_write), 64'd0);
      check("reset_addr",  64'(bus.rf_addr),  64'd0);
      check("reset_data",  64'(bus.rf_data),  64'd0);
    end
    rst = 1'b0;
    for (int s = 0; s < N_SRC; s++) set_src(s, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("post_reset_write", 64'(bus.rf_write), 64'd0);
      step();
    end

    // Table-driven contention with producers advancing on each handshake.
    for (int s = 0; s < N_SRC; s++) item[s] = 0;
    bus.rd2_addr = 5'd4;
    for (int i = 0; i < 13; i++) begin
      for (int s = 0; s < N_SRC; s++) begin
        set_src(s, 1'b1, W_ADDR'(s + 1), 32'hA000_0000 + (32'(s) << 16) + 32'(item[s]));
      end
      bus.rd1_addr = vecs[i].rd1;
      #1;
      check($sformatf("cont_ready[%0d]", i), 64'(bus.src_ready), 64'(vecs[i].ready));
      check($sformatf("cont_write[%0d]", i), 64'(bus.rf_write),  64'(vecs[i].wr));
      check($sformatf("cont_addr[%0d]", i),  64'(bus.rf_addr),   64'(vecs[i].addr));
      check($sformatf("cont_data[%0d]", i),  64'(bus.rf_data),   64'(vecs[i].data));
      check($sformatf("cont_hz1[%0d]", i),   64'(bus.hazard1),   64'(vecs[i].hz1));
      check($sformatf("cont_hz2[%0d]", i),   64'(bus.hazard2),   64'd0);
      acc = bus.src_valid & bus.src_ready;
      step();
      for (int s = 0; s < N_SRC; s++) item[s] += int'(acc[s]);
    end
    for (int s = 0; s < N_SRC; s++) set_src(s, 1'b0, '0, '0);
    repeat (10) step();
    #1;
    check("drain_ready", 64'(bus.src_ready), 64'(3'b111));
    check("drain_write", 64'(bus.rf_write),  64'd0);

    // x0 destination: handshake completes, nothing is written or flagged.
    set_src(1, 1'b1, 5'd0, 32'h0000_1234);
    bus.rd1_addr = 5'd0;
    #1;
    check("x0_ready", 64'(bus.src_ready), 64'(3'b111));
    step();
    set_src(1, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("x0_write", 64'(bus.rf_write), 64'd0);
      check("x0_hz1",   64'(bus.hazard1),  64'd0);
      step();
    end

    // Single write: visible to hazard from T+1, written at T+2 only.
    set_src(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    bus.rd1_addr = 5'd5;
    bus.rd2_addr = 5'd6;
    #1;
    check("single_hz1_T", 64'(bus.hazard1), 64'd0);
    step();
    set_src(0, 1'b0, '0, '0);
    #1;
    check("single_hz1_T1",   64'(bus.hazard1),  64'd1);
    check("single_write_T1", 64'(bus.rf_write), 64'd0);
    step(); #1;
    check("single_write_T2", 64'(bus.rf_write), 64'd1);
    check("single_addr_T2",  64'(bus.rf_addr),  64'd5);
    check("single_data_T2",  64'(bus.rf_data),  64'hDEAD_BEEF);
    check("single_hz1_T2",   64'(bus.hazard1),  64'd1);
    check("single_hz2_T2",   64'(bus.hazard2),  64'd0);
    step(); #1;
    check("single_write_T3", 64'(bus.rf_write), 64'd0);
    check("single_hz1_T3",   64'(bus.hazard1),  64'd0);
    check("single_addr_hold", 64'(bus.rf_addr), 64'd5);
    check("single_data_hold", 64'(bus.rf_data), 64'hDEAD_BEEF);

    // Per-source order under competition from src0.
    bus.rd1_addr = '0;
    bus.rd2_addr = 5'd8;
    set_src(0, 1'b1, 5'd10, 32'h0000_00B0);
    set_src(2, 1'b1, 5'd7,  32'h0000_0007);
    #1;
    step();
    set_src(0, 1'b1, 5'd11, 32'h0000_00B1);
    set_src(2, 1'b1, 5'd8,  32'h0000_0008);
    #1;
    check("bp_ready", 64'(bus.src_ready & 3'b101), 64'(3'b101));
    check("bp_hz2_incoming", 64'(bus.hazard2), 64'd0);
    step();
    set_src(0, 1'b0, '0, '0);
    set_src(2, 1'b0, '0, '0);
    #1;
    check("bp_hz2_queued", 64'(bus.hazard2), 64'd1);
    n0 = 0; n2 = 0; ntot = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.rf_write) begin
        ntot++;
        if ((bus.rf_addr == 5'd7 || bus.rf_addr == 5'd8) && n2 < 4) begin
          seq2[n2] = bus.rf_addr; n2++;
        end
        if ((bus.rf_addr == 5'd10 || bus.rf_addr == 5'd11) && n0 < 4) begin
          seq0[n0] = bus.rf_addr; n0++;
        end
      end
      step(); #1;
    end
    check("bp_total_writes", 64'(ntot), 64'd4);
    check("bp_src2_count",   64'(n2),   64'd2);
    check("bp_src0_count",   64'(n0),   64'd2);
    if (n2 == 2) begin
      check("bp_src2_first",  64'(seq2[0]), 64'd7);
      check("bp_src2_second", 64'(seq2[1]), 64'd8);
    end
    if (n0 == 2) begin
      check("bp_src0_first",  64'(seq0[0]), 64'd10);
      check("bp_src0_second", 64'(seq0[1]), 64'd11);
    end

    // Reset in the middle of traffic discards every queued entry.
    step();
    bus.rd1_addr = 5'd20;
    bus.rd2_addr = 5'd22;
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < N_SRC; s++) set_src(s, 1'b1, W_ADDR'(20 + s), 32'hC000_0000 + 32'(s));
      step();
    end
    for (int s = 0; s < N_SRC; s++) set_src(s, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    check("midrst_ready_in_rst", 64'(bus.src_ready), 64'(3'b000));
    step();
    rst = 1'b0;
    #1;
    check("midrst_ready", 64'(bus.src_ready), 64'(3'b111));
    for (int c = 0; c < 3; c++) begin
      check("midrst_write", 64'(bus.rf_write), 64'd0);
      check("midrst_hz1",   64'(bus.hazard1),  64'd0);
      check("midrst_hz2",   64'(bus.hazard2),  64'd0);
      step(); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
